// File: rtl/batalha_naval_seq_if.sv
// Handshake and status bundle for the battleship round.
// The master side (the player decoders) drives new_game, placements and shots.
// The slave side (the game core) drives readies, result pulses and status.
interface batalha_naval_seq_if #(
  parameter int unsigned POS_W     = 3,
  parameter int unsigned NUM_SHIPS = 2,
  parameter int unsigned MAX_SHOTS = 4
);
  localparam int unsigned SHOT_W = $clog2(MAX_SHOTS + 1);
  localparam int unsigned HIT_W  = $clog2(NUM_SHIPS + 1);

  logic              new_game;
  logic              place_valid;
  logic [POS_W-1:0]  place_pos;
  logic              place_ready;
  logic              place_err;
  logic              shot_valid;
  logic [POS_W-1:0]  shot_pos;
  logic              shot_ready;
  logic              hit;
  logic              miss;
  logic              dup;
  logic [SHOT_W-1:0] shots_left;
  logic [HIT_W-1:0]  hits_count;
  logic              done;
  logic              winner;

  modport master (
    output new_game, place_valid, place_pos, shot_valid, shot_pos,
    input  place_ready, place_err, shot_ready, hit, miss, dup,
    input  shots_left, hits_count, done, winner
  );

  modport slave (
    input  new_game, place_valid, place_pos, shot_valid, shot_pos,
    output place_ready, place_err, shot_ready, hit, miss, dup,
    output shots_left, hits_count, done, winner
  );
endinterface

// File: rtl/batalha_naval_seq.sv
// Sequential battleship round: player 1 places NUM_SHIPS key-encoded ships,
// player 2 fires up to MAX_SHOTS shots, each scored hit/miss/dup.
// All outputs are driven from registers, never from the valid inputs.
module batalha_naval_seq #(
  parameter int unsigned      POS_W     = 3,
  parameter int unsigned      NUM_SHIPS = 2,
  parameter int unsigned      MAX_SHOTS = 4,
  parameter logic [POS_W-1:0] KEY       = '0
) (
  input logic                clk,
  input logic                rst,
  batalha_naval_seq_if.slave bus
);
  localparam int unsigned SW = $clog2(MAX_SHOTS + 1);
  localparam int unsigned HW = $clog2(NUM_SHIPS + 1);

  typedef enum logic [1:0] {StPlace, StPlay, StOver} state_e;

  state_e                          r_state, w_state_d;
  logic [NUM_SHIPS-1:0][POS_W-1:0] r_table, w_table_d;
  logic [NUM_SHIPS-1:0]            r_used, w_used_d;
  logic [NUM_SHIPS-1:0]            r_sunk, w_sunk_d;
  logic [HW-1:0]                   r_placed, w_placed_d;
  logic [SW-1:0]                   r_shots, w_shots_d;
  logic [HW-1:0]                   r_hits, w_hits_d;
  logic                            r_winner, w_winner_d;
  logic                            r_err, w_err_d;
  logic                            r_hit, w_hit_d;
  logic                            r_miss, w_miss_d;
  logic                            r_dup, w_dup_d;

  logic [POS_W-1:0]                w_place_enc;
  logic                            w_place_match;
  logic [NUM_SHIPS-1:0]            w_shot_match;

  // Table lookups: duplicate check for placements and ship match for shots.
  always_comb begin
    w_place_enc   = bus.place_pos ^ KEY;
    w_place_match = 1'b0;
    w_shot_match  = '0;
    for (int unsigned i = 0; i < NUM_SHIPS; i++) begin
      if (r_used[i] && (r_table[i] == w_place_enc)) w_place_match = 1'b1;
      w_shot_match[i] = r_used[i] && (r_table[i] == bus.shot_pos);
    end
  end

  // Next-state and scoring; new_game overrides any same-cycle transfer.
  always_comb begin
    w_state_d  = r_state;
    w_table_d  = r_table;
    w_used_d   = r_used;
    w_sunk_d   = r_sunk;
    w_placed_d = r_placed;
    w_shots_d  = r_shots;
    w_hits_d   = r_hits;
    w_winner_d = r_winner;
    w_err_d    = 1'b0;
    w_hit_d    = 1'b0;
    w_miss_d   = 1'b0;
    w_dup_d    = 1'b0;
    if (bus.new_game) begin
      w_state_d  = StPlace;
      w_table_d  = '0;
      w_used_d   = '0;
      w_sunk_d   = '0;
      w_placed_d = '0;
      w_shots_d  = SW'(MAX_SHOTS);
      w_hits_d   = '0;
      w_winner_d = 1'b0;
    end else begin
      unique case (r_state)
        StPlace: begin
          if (bus.place_valid) begin
            if (w_place_match) begin
              w_err_d = 1'b1;
            end else begin
              for (int unsigned i = 0; i < NUM_SHIPS; i++) begin
                if (HW'(i) == r_placed) begin
                  w_used_d[i]  = 1'b1;
                  w_table_d[i] = w_place_enc;
                end
              end
              w_placed_d = r_placed + HW'(1);
              if (r_placed == HW'(NUM_SHIPS - 1)) w_state_d = StPlay;
            end
          end
        end
        StPlay: begin
          if (bus.shot_valid && (r_shots != '0)) begin
            w_shots_d = r_shots - SW'(1);
            if (|(w_shot_match & ~r_sunk)) begin
              w_hit_d  = 1'b1;
              w_sunk_d = r_sunk | w_shot_match;
              w_hits_d = r_hits + HW'(1);
            end else if (|w_shot_match) begin
              w_dup_d = 1'b1;
            end else begin
              w_miss_d = 1'b1;
            end
            // Sinking the last ship wins even if it was also the last shot.
            if (w_hits_d == HW'(NUM_SHIPS)) begin
              w_state_d  = StOver;
              w_winner_d = 1'b1;
            end else if (w_shots_d == '0) begin
              w_state_d  = StOver;
              w_winner_d = 1'b0;
            end
          end
        end
        StOver:  ;
        default: w_state_d = StPlace;
      endcase
    end
  end

  // State and scoreboard registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StPlace;
      r_table  <= '0;
      r_used   <= '0;
      r_sunk   <= '0;
      r_placed <= '0;
      r_shots  <= SW'(MAX_SHOTS);
      r_hits   <= '0;
      r_winner <= 1'b0;
      r_err    <= 1'b0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_dup    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_table  <= w_table_d;
      r_used   <= w_used_d;
      r_sunk   <= w_sunk_d;
      r_placed <= w_placed_d;
      r_shots  <= w_shots_d;
      r_hits   <= w_hits_d;
      r_winner <= w_winner_d;
      r_err    <= w_err_d;
      r_hit    <= w_hit_d;
      r_miss   <= w_miss_d;
      r_dup    <= w_dup_d;
    end
  end

  assign bus.place_ready = (r_state == StPlace);
  assign bus.shot_ready  = (r_state == StPlay);
  assign bus.done        = (r_state == StOver);
  assign bus.place_err   = r_err;
  assign bus.hit         = r_hit;
  assign bus.miss        = r_miss;
  assign bus.dup         = r_dup;
  assign bus.shots_left  = r_shots;
  assign bus.hits_count  = r_hits;
  assign bus.winner      = r_winner;
endmodule
